// File: rtl/tx_arbiter.sv
// tx_arbiter
//
// Transmit-side arbiter for the PCIe transaction layer. Requests from five
// lanes are logged in arrival order by a small sequence recorder (FIFO).
// Grants are then issued strictly in that order. Lanes that arrive together
// share one recorder entry and are granted from lane 0 up to lane 4.
//
// Lane map: 0 = A2P_1 read, 1 = A2P_2 write, 2 = Master completion,
//           3 = Rx Router completion, 4 = Rx Router message.
//
// Parameters:
//   DATA_WIDTH      recorder entry width, one bit per lane (must be 5)
//   FIFO_DEPTH      number of recorder entries (power of two, >= 2)
//
// Ports:
//   clk             clock, rising edge
//   arst            asynchronous active-low reset
//   a2p1_valid      lane 0 request
//   a2p2_valid      lane 1 request
//   master_valid    lane 2 request
//   rx_router_valid lanes 3 (bit0) and 4 (bit1) requests
//   tl_ready        downstream accepts a TLP this cycle
//   a2p1_grant      lane 0 one-cycle grant
//   a2p2_grant      lane 1 one-cycle grant
//   master_grant    lane 2 one-cycle grant
//   rx_router_grant lanes 3/4 one-cycle grants
//   sel             index of the lane granted this cycle
//   sel_valid       a grant is active this cycle
//   fifo_full       recorder full
//   fifo_empty      recorder empty
//   fifo_count      recorder occupancy (only with TX_ARBITER_STATUS_EN)
//
// Build option:
//   TX_ARBITER_STATUS_EN  when defined, adds the fifo_count output.
//
// All outputs are registered.

module tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           a2p1_valid,
    input  logic                           a2p2_valid,
    input  logic                           master_valid,
    input  logic [1:0]                     rx_router_valid,
    input  logic                           tl_ready,
    output logic                           a2p1_grant,
    output logic                           a2p2_grant,
    output logic                           master_grant,
    output logic [1:0]                     rx_router_grant,
    output logic [2:0]                     sel,
    output logic                           sel_valid,
    output logic                           fifo_full,
    output logic                           fifo_empty
`ifdef TX_ARBITER_STATUS_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] req_vec;
    logic [DATA_WIDTH-1:0] new_req;
    logic [DATA_WIDTH-1:0] pending_q, pending_d;
    logic [DATA_WIDTH-1:0] grant_q, grant_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [DATA_WIDTH-1:0] eff_work;
    logic [DATA_WIDTH-1:0] pick;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        push, pop;
    logic [2:0]  sel_q, sel_d;
    logic        sel_valid_q, sel_valid_d;

    // Next-state logic for recorder, work register, pending flags and grants.
    always_comb begin
        req_vec = {rx_router_valid, master_valid, a2p2_valid, a2p1_valid};
        // A lane showing its grant this cycle still has valid high; mask it so
        // the held request is not recorded a second time.
        new_req = req_vec & ~pending_q & ~grant_q;

        // The head is only taken when it can be granted immediately, so a
        // stalled downstream leaves both the work register and the FIFO alone.
        pop  = tl_ready && (work_q == '0) && !empty_q;
        // A pop in the same cycle frees the slot the push needs.
        push = (|new_req) && (!full_q || pop);

        // Granting straight from the popped head gives the first grant in the
        // cycle after the pop rather than one cycle later.
        eff_work = pop ? mem_q[rd_ptr_q[AW-1:0]] : work_q;
        // Isolate the lowest set bit.
        pick     = eff_work & (~eff_work + DATA_WIDTH'(1));

        grant_d = tl_ready ? pick : '0;
        work_d  = tl_ready ? (eff_work & ~pick) : work_q;

        pending_d = (pending_q & ~grant_d) | (push ? new_req : '0);

        sel_valid_d = |grant_d;
        sel_d       = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (grant_d[i]) begin
                sel_d = 3'(i);
            end
        end

        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pending_q   <= '0;
            work_q      <= '0;
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pending_q   <= pending_d;
            work_q      <= work_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    // Recorder storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_req;
        end
    end

`ifdef TX_ARBITER_STATUS_EN
    logic [AW:0] count_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count_q <= '0;
        end else begin
            count_q <= wr_ptr_d - rd_ptr_d;
        end
    end

    assign fifo_count = count_q;
`endif

    assign a2p1_grant      = grant_q[0];
    assign a2p2_grant      = grant_q[1];
    assign master_grant    = grant_q[2];
    assign rx_router_grant = grant_q[4:3];
    assign sel             = sel_q;
    assign sel_valid       = sel_valid_q;
    assign fifo_full       = full_q;
    assign fifo_empty      = empty_q;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

    localparam int DEPTH = 4;

    logic       clk  = 1'b0;
    logic       arst = 1'b0;
    logic [4:0] valid_v = '0;
    logic       tl_ready = 1'b1;

    logic       a2p1_grant, a2p2_grant, master_grant;
    logic [1:0] rx_router_grant;
    logic [2:0] sel;
    logic       sel_valid, fifo_full, fifo_empty;
`ifdef TX_ARBITER_STATUS_EN
    logic [$clog2(DEPTH):0] fifo_count;
`endif

    logic [4:0] dut_g;
    assign dut_g = {rx_router_grant, master_grant, a2p2_grant, a2p1_grant};

    always #5 clk = ~clk;

    tx_arbiter #(
        .DATA_WIDTH (5),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .a2p1_valid      (valid_v[0]),
        .a2p2_valid      (valid_v[1]),
        .master_valid    (valid_v[2]),
        .rx_router_valid (valid_v[4:3]),
        .tl_ready        (tl_ready),
        .a2p1_grant      (a2p1_grant),
        .a2p2_grant      (a2p2_grant),
        .master_grant    (master_grant),
        .rx_router_grant (rx_router_grant),
        .sel             (sel),
        .sel_valid       (sel_valid),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty)
`ifdef TX_ARBITER_STATUS_EN
        ,
        .fifo_count      (fifo_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: order queue of lane masks, current entry being served,
    // per-lane pending flags, and the grant shown this cycle.
    logic [4:0] mq[$];
    logic [4:0] m_work  = '0;
    logic [4:0] m_pend  = '0;
    logic [4:0] m_grant = '0;
    logic [2:0] m_sel   = '0;

    task automatic model_reset();
        mq.delete();
        m_work  = '0;
        m_pend  = '0;
        m_grant = '0;
        m_sel   = '0;
    endtask

    task automatic model_step();
        logic [4:0] newm, cur, g;
        bit         take, rec;
        newm = valid_v & ~m_pend & ~m_grant;
        take = tl_ready && (m_work == 0) && (mq.size() != 0);
        rec  = (newm != 0) && ((mq.size() < DEPTH) || take);
        cur  = take ? mq[0] : m_work;
        g    = '0;
        m_sel = '0;
        if (tl_ready) begin
            for (int i = 0; i < 5; i++) begin
                if (cur[i]) begin
                    g[i]  = 1'b1;
                    m_sel = 3'(i);
                    break;
                end
            end
            m_work = cur & ~g;
        end
        if (take) void'(mq.pop_front());
        if (rec) mq.push_back(newm);
        m_pend  = (m_pend & ~g) | (rec ? newm : 5'b0);
        m_grant = g;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge arst);
            if (!arst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_outputs", {dut_g, sel, sel_valid, fifo_full, fifo_empty},
                {m_grant, m_sel, |m_grant, mq.size() == DEPTH, mq.size() == 0});
`ifdef TX_ARBITER_STATUS_EN
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
`endif
        end
    end

    // Source behaviour: drop valid in the cycle after the grant is seen.
    logic [4:0] seen;
    initial begin
        forever begin
            @(negedge clk);
            seen = dut_g;
            @(posedge clk);
            #2;
            valid_v = valid_v & ~seen;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        neg();
        neg();
        chk("rst_grants", 32'(dut_g), 32'h0);
        chk("rst_sel", 32'({sel, sel_valid}), 32'h0);
        chk("rst_flags", 32'({fifo_full, fifo_empty}), 32'h1);
        tick();
        arst = 1'b1;
        repeat (2) tick();

        // Single source, grant two cycles after valid
        tick();
        valid_v[0] = 1'b1;
        neg(); chk("t1_n_empty", 32'({fifo_empty, sel_valid}), 32'h2);
        neg(); chk("t1_n1_pushed", 32'({fifo_empty, sel_valid}), 32'h0);
        neg(); chk("t1_n2_grant", 32'({dut_g, sel, sel_valid}), {23'd0, 5'b00001, 3'd0, 1'b1});
        chk("t1_n2_empty", 32'(fifo_empty), 32'h1);
        neg(); chk("t1_n3_nogrant", 32'({dut_g, sel_valid}), 32'h0);
        repeat (3) tick();

        // All five lanes in one cycle
        tick();
        valid_v = 5'b11111;
        neg(); neg();
        for (int k = 0; k < 5; k++) begin
            neg();
            chk("t2_sel", 32'({sel, sel_valid}), 32'({3'(k), 1'b1}));
            chk("t2_grant", 32'(dut_g), 32'(5'b00001 << k));
        end
        neg(); chk("t2_done", 32'(sel_valid), 32'h0);
        repeat (3) tick();

        // Ordering across entries
        tick();
        valid_v[2] = 1'b1;
        tick();
        valid_v[0] = 1'b1;
        neg(); chk("t3_n1", 32'(sel_valid), 32'h0);
        neg(); chk("t3_master_first", 32'({sel, sel_valid}), 32'({3'd2, 1'b1}));
        neg(); chk("t3_a2p1_second", 32'({sel, sel_valid}), 32'({3'd0, 1'b1}));
        repeat (3) tick();

        // Backpressure
        tick();
        tl_ready   = 1'b0;
        valid_v[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            neg();
            chk("t4_held", 32'(sel_valid), 32'h0);
        end
        tick();
        tl_ready = 1'b1;
        neg(); chk("t4_release_cycle", 32'(sel_valid), 32'h0);
        neg(); chk("t4_grant", 32'({sel, sel_valid}), 32'({3'd1, 1'b1}));
        repeat (3) tick();

        // Full recorder
        tick();
        tl_ready   = 1'b0;
        valid_v[0] = 1'b1;
        tick(); valid_v[1] = 1'b1;
        tick(); valid_v[2] = 1'b1;
        tick(); valid_v[3] = 1'b1;
        tick(); valid_v[4] = 1'b1;
        neg(); chk("t5_full", 32'({fifo_full, fifo_empty}), 32'h2);
        tick();
        neg(); chk("t5_full_hold", 32'({fifo_full, sel_valid}), 32'h2);
        tick();
        tl_ready = 1'b1;
        neg(); chk("t5_release_cycle", 32'(sel_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            neg();
            chk("t5_order", 32'({sel, sel_valid}), 32'({3'(k), 1'b1}));
            if (k == 0) chk("t5_push_pop_full", 32'(fifo_full), 32'h1);
        end
        neg(); chk("t5_done", 32'({sel_valid, fifo_empty}), 32'h1);
        repeat (3) tick();

        // Reset with entries queued
        tick();
        tl_ready   = 1'b0;
        valid_v[0] = 1'b1;
        tick();
        valid_v[1] = 1'b1;
        tick();
        arst    = 1'b0;
        valid_v = '0;
        #1;
        chk("t6_rst_flags", 32'({fifo_full, fifo_empty}), 32'h1);
        chk("t6_rst_outs", 32'({dut_g, sel, sel_valid}), 32'h0);
        tick();
        tick();
        arst     = 1'b1;
        tl_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            neg();
            chk("t6_no_grant", 32'({sel_valid, fifo_empty}), 32'h1);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
